// File: rtl/dmem_pkg.sv
// Shared types and helpers for the multi-cycle data-memory responder.
package dmem_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_e;

  localparam int LAT_CNT_W = 4;

  // Word index of a byte address, wrapped to an addr_w-bit storage index.
  function automatic logic [31:0] word_index(input logic [31:0] addr, input int addr_w);
    logic [31:0] mask;
    mask = (32'd1 << addr_w) - 32'd1;
    return (addr >> 2) & mask;
  endfunction

endpackage

// File: rtl/dmem_array.sv
// DEPTH_WORDS x 32 storage: synchronous write, combinational read, never cleared.
module dmem_array #(
  parameter int DEPTH_WORDS = 256,
  parameter int ADDR_W      = 8
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [31:0]       wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [31:0]       rdata
);

  logic [31:0] mem [DEPTH_WORDS];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/dmem_responder.sv
// MEM-stage load/store target that stalls the pipeline for LATENCY cycles per access.
// Optional address checking is enabled with DMEM_RESPONDER_ERR_CHECK_EN.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int DEPTH_WORDS = 256,
  parameter int LATENCY     = 3,
  parameter int ADDR_W      = 8
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] write_data_i,
  input  logic        MemRead_i,
  input  logic        MemWrite_i,
  output logic [31:0] data_o,
  output logic        stall_o,
  output logic        ack_o,
  output logic        err_o
);

  state_e                 state_q, state_d;
  logic [LAT_CNT_W-1:0]   cnt_q, cnt_d;
  logic                   wr_q, wr_d;
  logic [ADDR_W-1:0]      idx_q, idx_d;
  logic [31:0]            wdata_q, wdata_d;
  logic [31:0]            data_q, data_d;
  logic                   ack_q, ack_d;
  logic                   err_q, err_d;
  logic                   flag_q, flag_d;

  logic                   req_s;
  logic                   we_s;
  logic                   bad_s;
  logic [ADDR_W-1:0]      idx_s;
  logic [31:0]            rdata_s;

  assign req_s = MemRead_i | MemWrite_i;
  assign idx_s = ADDR_W'(word_index(addr_i, ADDR_W));

`ifdef DMEM_RESPONDER_ERR_CHECK_EN
  assign bad_s = (addr_i[1:0] != 2'b00) || (addr_i >= 32'(4 * DEPTH_WORDS));
`else
  assign bad_s = 1'b0;
`endif

  dmem_array #(
    .DEPTH_WORDS(DEPTH_WORDS),
    .ADDR_W     (ADDR_W)
  ) u_array (
    .clk  (clk_i),
    .we   (we_s),
    .waddr(idx_q),
    .wdata(wdata_q),
    .raddr(idx_q),
    .rdata(rdata_s)
  );

  // Next-state logic; a store wins over a simultaneous load request.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    wr_d    = wr_q;
    idx_d   = idx_q;
    wdata_d = wdata_q;
    data_d  = data_q;
    err_d   = err_q;
    flag_d  = flag_q;
    ack_d   = 1'b0;
    we_s    = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_s) begin
          state_d = ACCESS;
          cnt_d   = LAT_CNT_W'(LATENCY - 1);
          wr_d    = MemWrite_i;
          idx_d   = idx_s;
          wdata_d = write_data_i;
          flag_d  = bad_s;
        end else begin
          state_d = IDLE;
        end
      end
      ACCESS: begin
        if (cnt_q == 4'd0) begin
          state_d = DONE;
          ack_d   = 1'b1;
          err_d   = err_q | flag_q;
          if (wr_q) begin
            we_s = ~flag_q;
          end else begin
            data_d = flag_q ? 32'd0 : rdata_s;
          end
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers; reset aborts any in-flight access.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      wr_q    <= 1'b0;
      idx_q   <= '0;
      wdata_q <= 32'd0;
      data_q  <= 32'd0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      flag_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      wr_q    <= wr_d;
      idx_q   <= idx_d;
      wdata_q <= wdata_d;
      data_q  <= data_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
      flag_q  <= flag_d;
    end
  end

  // The acceptance cycle must stall before the request is registered.
  assign stall_o = (state_q == ACCESS) || ((state_q == IDLE) && req_s);
  assign data_o  = data_q;
  assign ack_o   = ack_q;
  assign err_o   = err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed self-checking bench for dmem_responder (DEPTH_WORDS=256, LATENCY=3).
module tb_dmem_responder;

  localparam int LAT = 3;

  logic        clk;
  logic        rst;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        mem_rd;
  logic        mem_wr;
  logic [31:0] data_o;
  logic        stall_o;
  logic        ack_o;
  logic        err_o;

  int          n_chk;
  int          n_bad;
  int          cyc;
  int          last_ack;
  int          t0;
  logic [31:0] model_q;

  dmem_responder #(
    .DEPTH_WORDS(256),
    .LATENCY    (LAT),
    .ADDR_W     (8)
  ) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .addr_i      (addr),
    .write_data_i(wdata),
    .MemRead_i   (mem_rd),
    .MemWrite_i  (mem_wr),
    .data_o      (data_o),
    .stall_o     (stall_o),
    .ack_o       (ack_o),
    .err_o       (err_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc = cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk = n_chk + 1;
    if (got !== exp) begin
      n_bad = n_bad + 1;
      $display("FAIL %s: got=%08h expected=%08h", tag, got, exp);
    end
  endtask

  // One full access; data_o must hold model_q while stalled, then show exp_data at ack.
  task automatic access(input logic rd, input logic wr, input logic [31:0] a,
                        input logic [31:0] wd, input logic [31:0] exp_data,
                        input logic exp_err);
    @(negedge clk);
    mem_rd = rd;
    mem_wr = wr;
    addr   = a;
    wdata  = wd;
    #1;
    chk("stall_accept", {31'd0, stall_o}, 32'd1);
    chk("ack_accept", {31'd0, ack_o}, 32'd0);
    for (int i = 1; i <= LAT; i++) begin
      @(negedge clk);
      chk("stall_access", {31'd0, stall_o}, 32'd1);
      chk("ack_access", {31'd0, ack_o}, 32'd0);
      chk("data_hold", data_o, model_q);
    end
    @(negedge clk);
    chk("stall_done", {31'd0, stall_o}, 32'd0);
    chk("ack_done", {31'd0, ack_o}, 32'd1);
    chk("data_done", data_o, exp_data);
    chk("err_done", {31'd0, err_o}, {31'd0, exp_err});
    last_ack = cyc;
    model_q  = exp_data;
    mem_rd   = 1'b0;
    mem_wr   = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    n_chk = 0; n_bad = 0; cyc = 0; last_ack = 0; model_q = 32'd0;
    rst = 1'b1; addr = 32'd0; wdata = 32'd0; mem_rd = 1'b0; mem_wr = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_data", data_o, 32'd0);
    chk("rst_stall", {31'd0, stall_o}, 32'd0);
    chk("rst_ack", {31'd0, ack_o}, 32'd0);
    chk("rst_err", {31'd0, err_o}, 32'd0);
    rst = 1'b0;

    // Store then load.
    access(1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 32'd0, 1'b0);
    access(1'b1, 1'b0, 32'h10, 32'd0, 32'hDEADBEEF, 1'b0);

    // Simultaneous read+write: store wins, data_o untouched.
    access(1'b1, 1'b1, 32'h20, 32'h12345678, 32'hDEADBEEF, 1'b0);
    access(1'b1, 1'b0, 32'h20, 32'd0, 32'h12345678, 1'b0);

    // Seed words used below.
    access(1'b0, 1'b1, 32'h04, 32'h0BADF00D, 32'h12345678, 1'b0);
    access(1'b0, 1'b1, 32'h00, 32'h000000A0, 32'h12345678, 1'b0);
    access(1'b0, 1'b1, 32'h08, 32'h000000A8, 32'h12345678, 1'b0);

    // Reset during the 2nd ACCESS cycle of a store.
    @(negedge clk);
    mem_wr = 1'b1; addr = 32'h04; wdata = 32'hCAFEF00D;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1; mem_wr = 1'b0;
    #1;
    chk("midrst_stall", {31'd0, stall_o}, 32'd0);
    chk("midrst_data", data_o, 32'd0);
    chk("midrst_ack", {31'd0, ack_o}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    model_q = 32'd0;
    access(1'b1, 1'b0, 32'h04, 32'd0, 32'h0BADF00D, 1'b0);

    // Back-to-back loads.
    access(1'b1, 1'b0, 32'h00, 32'd0, 32'h000000A0, 1'b0);
    t0 = last_ack;
    access(1'b1, 1'b0, 32'h04, 32'd0, 32'h0BADF00D, 1'b0);
    chk("b2b_gap1", 32'(last_ack - t0), 32'd5);
    t0 = last_ack;
    access(1'b1, 1'b0, 32'h08, 32'd0, 32'h000000A8, 1'b0);
    chk("b2b_gap2", 32'(last_ack - t0), 32'd5);

`ifdef DMEM_RESPONDER_ERR_CHECK_EN
    access(1'b1, 1'b0, 32'h402, 32'd0, 32'd0, 1'b1);
    access(1'b0, 1'b1, 32'h401, 32'hFFFFFFFF, 32'd0, 1'b1);
    access(1'b1, 1'b0, 32'h000, 32'd0, 32'h000000A0, 1'b1);
    @(negedge clk);
    chk("err_sticky", {31'd0, err_o}, 32'd1);
    rst = 1'b1;
    #1;
    chk("err_clear", {31'd0, err_o}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
`else
    access(1'b0, 1'b1, 32'h400, 32'h00000011, 32'h000000A8, 1'b0);
    access(1'b1, 1'b0, 32'h000, 32'd0, 32'h00000011, 1'b0);
    @(negedge clk);
    chk("err_tied", {31'd0, err_o}, 32'd0);
`endif

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
